// File: rtl/pipelined_logic_unit_pkg.sv
// Shared types and the per-bit operation evaluator for the pipelined logic unit.
package pipelined_logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } logic_op_t;

  // Control bits that travel alongside the result through every pipeline slot.
  typedef struct packed {
    logic valid;
    logic zero;
    logic negative;
  } stage_ctl_t;

  // Every op is bitwise, so evaluating one bit position is exact for any width.
  function automatic logic logic_eval(input logic a, input logic b, input logic_op_t op);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_NAND:  r = ~(a & b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      OP_PASSA: r = a;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipelined_logic_unit_if.sv
// Upstream operand handshake and downstream result handshake of the logic unit.
interface pipelined_logic_unit_if
  import pipelined_logic_unit_pkg::*;
#(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic_op_t        op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, negative
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, negative
  );

endinterface

// File: rtl/pipelined_logic_unit_stage.sv
// One pipeline slot: valid, result and flags, loaded when the pipe advances.
module pipelined_logic_unit_stage
  import pipelined_logic_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  stage_ctl_t       i_ctl,
  input  logic [WIDTH-1:0] i_result,
  output stage_ctl_t       o_ctl,
  output logic [WIDTH-1:0] o_result
);

  stage_ctl_t       r_ctl;
  logic [WIDTH-1:0] r_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctl    <= '0;
      r_result <= '0;
    end else if (i_en) begin
      r_ctl    <= i_ctl;
      r_result <= i_result;
    end
  end

  assign o_ctl    = r_ctl;
  assign o_result = r_result;

endmodule

// File: rtl/pipelined_logic_unit.sv
// Pipelined bitwise logic unit: op and flags evaluated on input, then carried
// through STAGES slots that all advance together or all hold.
module pipelined_logic_unit
  import pipelined_logic_unit_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  pipelined_logic_unit_if.slave bus
);

  logic             w_advance;
  logic [WIDTH-1:0] w_eval;
  stage_ctl_t       w_ctl_s0;
  stage_ctl_t       w_ctl_out [STAGES];
  logic [WIDTH-1:0] w_res_out [STAGES];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_eval[gi] = logic_eval(bus.a[gi], bus.b[gi], bus.op);
  end

  // Whole pipe moves only when the output slot is empty or being drained.
  assign w_advance = !w_ctl_out[STAGES-1].valid || bus.out_ready;
  assign w_ctl_s0  = '{valid: bus.in_valid && w_advance, zero: ~|w_eval, negative: w_eval[WIDTH-1]};

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_ctl_t       w_ctl_in;
    logic [WIDTH-1:0] w_res_in;

    if (gi == 0) begin : g_first
      assign w_ctl_in = w_ctl_s0;
      assign w_res_in = w_eval;
    end else begin : g_next
      assign w_ctl_in = w_ctl_out[gi-1];
      assign w_res_in = w_res_out[gi-1];
    end

    pipelined_logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (w_advance),
      .i_ctl    (w_ctl_in),
      .i_result (w_res_in),
      .o_ctl    (w_ctl_out[gi]),
      .o_result (w_res_out[gi])
    );
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = w_ctl_out[STAGES-1].valid;
  assign bus.result    = w_res_out[STAGES-1];
  assign bus.zero      = w_ctl_out[STAGES-1].zero;
  assign bus.negative  = w_ctl_out[STAGES-1].negative;

endmodule
